// File: rtl/yolo_axi_pkg.sv
// Shared AXI constants and FSM state type for the YOLO AXI read arbiter.
package yolo_axi_pkg;

  localparam logic [1:0] AXI_BURST_INCR    = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY     = 2'b00;
  localparam logic [3:0] AXI_CACHE_DEFAULT = 4'b0011;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } rd_arb_state_e;

  // Index width that stays legal for a single requester.
  function automatic int unsigned idx_width(int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/yolo_rr_pick.sv
// Combinational requester pick: round-robin from last_grant_i + 1, or fixed lowest-index
// priority when YOLO_RD_ARB_FIXED_PRIO_EN is defined.
module yolo_rr_pick #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned IW    = 2
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [IW-1:0]    last_grant_i,
  output logic [N_REQ-1:0] gnt_o,
  output logic [IW-1:0]    idx_o,
  output logic             any_o
);

`ifdef YOLO_RD_ARB_FIXED_PRIO_EN
  logic unused_last_grant;
  assign unused_last_grant = ^last_grant_i;

  always_comb begin
    logic found;
    found = 1'b0;
    gnt_o = '0;
    idx_o = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (!found && req_i[i]) begin
        found    = 1'b1;
        gnt_o[i] = 1'b1;
        idx_o    = IW'(i);
      end
    end
    any_o = found;
  end
`else
  always_comb begin
    logic        found;
    int unsigned k;
    found = 1'b0;
    k     = 0;
    gnt_o = '0;
    idx_o = '0;
    // Walk last_grant+1 .. last_grant+N_REQ, wrapping past N_REQ-1 back to 0.
    for (int unsigned i = 1; i <= N_REQ; i++) begin
      k = (32'(last_grant_i) + i) % N_REQ;
      if (!found && req_i[k]) begin
        found    = 1'b1;
        gnt_o[k] = 1'b1;
        idx_o    = IW'(k);
      end
    end
    any_o = found;
  end
`endif

endmodule

// File: rtl/yolo_axi_rd_arb.sv
// Shares one AXI4 read master among N_REQ loaders, one INCR burst outstanding at a time.
// Define YOLO_RD_ARB_FIXED_PRIO_EN for fixed lowest-index priority instead of round-robin.
module yolo_axi_rd_arb
  import yolo_axi_pkg::*;
#(
  parameter int unsigned  N_REQ = 4,
  parameter int unsigned  A     = 32,
  parameter int unsigned  D     = 32,
  parameter int unsigned  I     = 4,
  parameter int unsigned  L     = 8,
  localparam int unsigned GW    = idx_width(N_REQ)
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic [N_REQ-1:0]   req_valid,
  output logic [N_REQ-1:0]   req_ready,
  input  logic [N_REQ*A-1:0] req_addr,
  input  logic [N_REQ*L-1:0] req_len,
  output logic [D-1:0]       rd_data,
  output logic [N_REQ-1:0]   rd_valid,
  output logic               rd_last,
  input  logic [N_REQ-1:0]   rd_ready,
  output logic               M_ARVALID,
  input  logic               M_ARREADY,
  output logic [A-1:0]       M_ARADDR,
  output logic [I-1:0]       M_ARID,
  output logic [L-1:0]       M_ARLEN,
  output logic [2:0]         M_ARSIZE,
  output logic [1:0]         M_ARBURST,
  output logic               M_ARLOCK,
  output logic [3:0]         M_ARCACHE,
  output logic [2:0]         M_ARPROT,
  input  logic               M_RVALID,
  output logic               M_RREADY,
  input  logic [D-1:0]       M_RDATA,
  input  logic [I-1:0]       M_RID,
  input  logic [1:0]         M_RRESP,
  input  logic               M_RLAST,
  output logic               busy,
  output logic [GW-1:0]      grant_id,
  output logic               rd_err
);

  localparam logic [2:0] AR_SIZE = 3'($clog2(D / 8));

  rd_arb_state_e    state_q, state_d;
  logic [GW-1:0]    last_grant_q;
  logic [A-1:0]     addr_q, sel_addr;
  logic [L-1:0]     len_q, sel_len;
  logic [N_REQ-1:0] pick_gnt, owner_oh, rd_valid_q;
  logic [GW-1:0]    pick_idx;
  logic             pick_any;
  logic [D-1:0]     rd_data_q;
  logic             rd_last_q, last_seen_q, rd_err_q;
  logic [I-1:0]     ar_id;
  logic             ar_valid, grant_en, out_consume, out_free, r_ready, r_hs, r_bad;

  yolo_rr_pick #(
    .N_REQ (N_REQ),
    .IW    (GW)
  ) u_pick (
    .req_i        (req_valid),
    .last_grant_i (last_grant_q),
    .gnt_o        (pick_gnt),
    .idx_o        (pick_idx),
    .any_o        (pick_any)
  );

  always_comb begin
    sel_addr = '0;
    sel_len  = '0;
    owner_oh = '0;
    ar_id    = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      if (pick_idx == GW'(k)) begin
        sel_addr = req_addr[k*A +: A];
        sel_len  = req_len[k*L +: L];
      end
    end
    owner_oh[last_grant_q] = 1'b1;
    ar_id[GW-1:0]          = last_grant_q;
  end

  always_comb begin
    ar_valid    = (state_q == ADDR);
    grant_en    = (state_q == IDLE) && pick_any;
    out_consume = |(rd_valid_q & rd_ready);
    out_free    = ~|rd_valid_q || out_consume;
    // last_seen_q blocks a stray beat between RLAST and the client taking it.
    r_ready     = (state_q == DATA) && !last_seen_q && rd_ready[last_grant_q] && out_free;
    r_hs        = M_RVALID && r_ready;
    r_bad       = (M_RRESP != AXI_RESP_OKAY) || (M_RID != ar_id);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (pick_any) state_d = ADDR;
      ADDR: if (M_ARREADY) state_d = DATA;
      DATA: if (out_consume && rd_last_q) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      last_grant_q <= GW'(N_REQ - 1);
      addr_q       <= '0;
      len_q        <= '0;
    end else if (grant_en) begin
      last_grant_q <= pick_idx;
      addr_q       <= sel_addr;
      len_q        <= sel_len;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rd_data_q   <= '0;
      rd_valid_q  <= '0;
      rd_last_q   <= 1'b0;
      last_seen_q <= 1'b0;
      rd_err_q    <= 1'b0;
    end else begin
      if (r_hs) begin
        rd_data_q  <= M_RDATA;
        rd_valid_q <= owner_oh;
        rd_last_q  <= M_RLAST;
      end else if (out_consume) begin
        rd_valid_q <= '0;
        rd_last_q  <= 1'b0;
      end
      if (grant_en) begin
        last_seen_q <= 1'b0;
      end else if (r_hs && M_RLAST) begin
        last_seen_q <= 1'b1;
      end
      if (r_hs && r_bad) begin
        rd_err_q <= 1'b1;
      end
    end
  end

  // Constant AR fields are only driven alongside ARVALID so the port idles at zero.
  assign req_ready = (state_q == IDLE) ? pick_gnt : '0;
  assign M_ARVALID = ar_valid;
  assign M_ARADDR  = addr_q;
  assign M_ARID    = ar_valid ? ar_id : '0;
  assign M_ARLEN   = len_q;
  assign M_ARSIZE  = ar_valid ? AR_SIZE : '0;
  assign M_ARBURST = ar_valid ? AXI_BURST_INCR : '0;
  assign M_ARLOCK  = 1'b0;
  assign M_ARCACHE = ar_valid ? AXI_CACHE_DEFAULT : '0;
  assign M_ARPROT  = 3'b000;
  assign M_RREADY  = r_ready;
  assign rd_data   = rd_data_q;
  assign rd_valid  = rd_valid_q;
  assign rd_last   = rd_last_q;
  assign busy      = (state_q != IDLE);
  assign grant_id  = last_grant_q;
  assign rd_err    = rd_err_q;

endmodule

// File: tb/tb_yolo_axi_rd_arb.sv
// Scoreboard bench for yolo_axi_rd_arb: bench-side AXI slave, beats queued on R handshake.
module tb_yolo_axi_rd_arb;

  logic        clk;
  logic        rstn;
  logic [3:0]  req_valid, req_ready, rd_valid, rd_ready;
  logic [127:0] req_addr;
  logic [31:0] req_len;
  logic [31:0] rd_data, M_ARADDR, M_RDATA;
  logic        rd_last, M_ARVALID, M_ARREADY, M_ARLOCK, M_RVALID, M_RREADY, M_RLAST;
  logic [3:0]  M_ARID, M_ARCACHE, M_RID;
  logic [7:0]  M_ARLEN;
  logic [2:0]  M_ARSIZE, M_ARPROT;
  logic [1:0]  M_ARBURST, M_RRESP, grant_id;
  logic        busy, rd_err;

  typedef struct packed {
    logic [3:0]  oh;
    logic [31:0] data;
    logic        last;
  } beat_t;

  beat_t sb[$];
  int    n_checks = 0;
  int    n_errs   = 0;

  yolo_axi_rd_arb #(
    .N_REQ (4),
    .A     (32),
    .D     (32),
    .I     (4),
    .L     (8)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_len   (req_len),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
    .rd_last   (rd_last),
    .rd_ready  (rd_ready),
    .M_ARVALID (M_ARVALID),
    .M_ARREADY (M_ARREADY),
    .M_ARADDR  (M_ARADDR),
    .M_ARID    (M_ARID),
    .M_ARLEN   (M_ARLEN),
    .M_ARSIZE  (M_ARSIZE),
    .M_ARBURST (M_ARBURST),
    .M_ARLOCK  (M_ARLOCK),
    .M_ARCACHE (M_ARCACHE),
    .M_ARPROT  (M_ARPROT),
    .M_RVALID  (M_RVALID),
    .M_RREADY  (M_RREADY),
    .M_RDATA   (M_RDATA),
    .M_RID     (M_RID),
    .M_RRESP   (M_RRESP),
    .M_RLAST   (M_RLAST),
    .busy      (busy),
    .grant_id  (grant_id),
    .rd_err    (rd_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
    end
  endtask

  // Client side: every consumed beat must match the head of the scoreboard.
  always @(negedge clk) begin
    beat_t e;
    if (rstn && ((rd_valid & rd_ready) != 4'b0)) begin
      if (sb.size() == 0) begin
        check_eq("extra_beat", 64'(rd_valid), 64'd0);
      end else begin
        e = sb.pop_front();
        check_eq("rd_valid", 64'(rd_valid), 64'(e.oh));
        check_eq("rd_data", 64'(rd_data), 64'(e.data));
        check_eq("rd_last", 64'(rd_last), 64'(e.last));
      end
    end
  end

  task automatic set_req(input int c, input logic [31:0] addr, input logic [7:0] len);
    req_valid[c]        = 1'b1;
    req_addr[c*32 +: 32] = addr;
    req_len[c*8 +: 8]    = len;
  endtask

  task automatic wait_grant(input int c, input bit hold);
    int w;
    w = 0;
    @(negedge clk);
    while (req_ready == 4'b0 && w < 50) begin
      @(negedge clk);
      w++;
    end
    check_eq("req_ready", 64'(req_ready), 64'd1 << c);
    @(posedge clk);
    #1;
    if (!hold) req_valid[c] = 1'b0;
  endtask

  task automatic do_burst(input int id, input logic [31:0] addr, input int len,
                          input int ar_stall, input int err_beat, input int nserve,
                          input bit full_rate);
    int          w;
    logic [31:0] data, prev;
    bit          pend;
    beat_t       e;
    w    = 0;
    prev = '0;
    @(negedge clk);
    while (!M_ARVALID && w < 20) begin
      @(negedge clk);
      w++;
    end
    check_eq("ar_valid", 64'(M_ARVALID), 64'd1);
    check_eq("ar_latency", 64'(w), 64'd0);
    check_eq("ar_addr", 64'(M_ARADDR), 64'(addr));
    check_eq("ar_id", 64'(M_ARID), 64'(id));
    check_eq("ar_len", 64'(M_ARLEN), 64'(len));
    check_eq("ar_const", 64'({M_ARSIZE, M_ARBURST, M_ARLOCK, M_ARCACHE, M_ARPROT}),
             64'({3'd2, 2'b01, 1'b0, 4'b0011, 3'b000}));
    check_eq("grant_id", 64'(grant_id), 64'(id));
    for (int s = 0; s < ar_stall; s++) begin
      @(posedge clk);
      #1;
      @(negedge clk);
      check_eq("ar_hold", 64'({M_ARVALID, M_ARID, M_ARLEN, M_ARADDR}),
               64'({1'b1, 4'(id), 8'(len), addr}));
    end
    M_ARREADY = 1'b1;
    @(posedge clk);
    #1;
    M_ARREADY = 1'b0;
    pend = 1'b0;
    for (int b = 0; b <= len && b < nserve; b++) begin
      data     = $urandom;
      M_RVALID = 1'b1;
      M_RDATA  = data;
      M_RID    = 4'(id);
      M_RLAST  = (b == len);
      M_RRESP  = (b == err_beat) ? 2'b10 : 2'b00;
      w = 0;
      @(negedge clk);
      forever begin
        if (pend) begin
          check_eq("beat_latency", 64'({rd_valid[id], rd_data}), 64'({1'b1, prev}));
          pend = 1'b0;
        end
        check_eq("rready_follow", 64'(M_RREADY), 64'(rd_ready[id]));
        if (M_RREADY || w >= 100) break;
        @(negedge clk);
        w++;
      end
      check_eq("r_handshake", 64'(M_RREADY), 64'd1);
      if (full_rate) check_eq("throughput", 64'(w), 64'd0);
      e.oh   = 4'(1 << id);
      e.data = data;
      e.last = (b == len);
      sb.push_back(e);
      prev = data;
      pend = 1'b1;
      @(posedge clk);
      #1;
    end
    M_RVALID = 1'b0;
    M_RLAST  = 1'b0;
    M_RRESP  = 2'b00;
    @(negedge clk);
    check_eq("beat_latency", 64'({rd_valid[id], rd_data}), 64'({1'b1, prev}));
    check_eq("busy_last", 64'(busy), 64'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset();
    check_eq("rst_ctl", 64'({req_ready, rd_valid, rd_last, M_ARVALID, M_ARID, M_ARLEN, M_ARSIZE,
                             M_ARBURST, M_ARLOCK, M_ARCACHE, M_ARPROT, M_RREADY, busy, rd_err}),
             64'd0);
    check_eq("rst_data", 64'(rd_data), 64'd0);
    check_eq("rst_araddr", 64'(M_ARADDR), 64'd0);
    check_eq("rst_grant_id", 64'(grant_id), 64'd3);
  endtask

  task automatic chk_drained();
    repeat (3) @(posedge clk);
    #1;
    check_eq("sb_left", 64'(sb.size()), 64'd0);
  endtask

  initial begin
    int ord[5];
`ifdef YOLO_RD_ARB_FIXED_PRIO_EN
    ord = '{0, 0, 0, 0, 0};
`else
    ord = '{0, 1, 2, 3, 0};
`endif
    rstn      = 1'b0;
    req_valid = '0;
    req_addr  = '0;
    req_len   = '0;
    rd_ready  = '1;
    M_ARREADY = 1'b0;
    M_RVALID  = 1'b0;
    M_RDATA   = '0;
    M_RID     = '0;
    M_RRESP   = 2'b00;
    M_RLAST   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset();
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    #1;

    // All four clients at once, single-beat bursts; client 0 keeps asking.
    for (int c = 0; c < 4; c++) set_req(c, 32'h2000 + 32'(c) * 32'h100, 8'd0);
    for (int g = 0; g < 5; g++) begin
      wait_grant(ord[g], (ord[g] == 0) && (g < 4));
      if (g == 4) req_valid = '0;
      do_burst(ord[g], 32'h2000 + 32'(ord[g]) * 32'h100, 0, 0, -1, 99, 1'b1);
    end
    chk_drained();

    // Single 4-beat burst from client 2.
    set_req(2, 32'h1000, 8'd3);
    wait_grant(2, 1'b0);
    do_burst(2, 32'h1000, 3, 0, -1, 99, 1'b1);
    @(negedge clk);
    check_eq("busy_fall", 64'(busy), 64'd0);
    @(posedge clk);
    #1;

    // AR stall: ARREADY low for five ARVALID cycles.
    set_req(3, 32'h3000_0040, 8'd1);
    wait_grant(3, 1'b0);
    do_burst(3, 32'h3000_0040, 1, 4, -1, 99, 1'b1);
    chk_drained();

    // 8-beat burst with rd_ready toggling 1,0,0,1.
    set_req(0, 32'h4000, 8'd7);
    wait_grant(0, 1'b0);
    fork
      do_burst(0, 32'h4000, 7, 0, -1, 99, 1'b0);
      begin
        for (int t = 0; t < 60; t++) begin
          rd_ready = ((t % 4 == 0) || (t % 4 == 3)) ? 4'hf : 4'h0;
          @(posedge clk);
          #1;
        end
        rd_ready = '1;
      end
    join
    chk_drained();

    // SLVERR on beat 2 of 4; rd_err must stick across the next burst.
    check_eq("err_pre", 64'(rd_err), 64'd0);
    set_req(1, 32'h5000, 8'd3);
    wait_grant(1, 1'b0);
    do_burst(1, 32'h5000, 3, 0, 1, 99, 1'b1);
    @(negedge clk);
    check_eq("err_set", 64'(rd_err), 64'd1);
    @(posedge clk);
    #1;
    set_req(3, 32'h6000, 8'd1);
    wait_grant(3, 1'b0);
    do_burst(3, 32'h6000, 1, 0, -1, 99, 1'b1);
    @(negedge clk);
    check_eq("err_sticky", 64'(rd_err), 64'd1);
    @(posedge clk);
    #1;

    // Reset mid-burst after beat 3 of 8, then a fresh request from client 1.
    set_req(2, 32'h7000, 8'd7);
    wait_grant(2, 1'b0);
    do_burst(2, 32'h7000, 7, 0, -1, 3, 1'b1);
    #2;
    rstn = 1'b0;
    #1;
    chk_reset();
    sb.delete();
    M_RVALID = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    #1;
    set_req(1, 32'h8000, 8'd2);
    wait_grant(1, 1'b0);
    do_burst(1, 32'h8000, 2, 0, -1, 99, 1'b1);
    chk_drained();

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule

// File: doc/yolo_axi_rd_arb.md
# yolo_axi_rd_arb

Read-channel arbiter for the YOLO engine's single AXI master port. It shares one AXI4 read address/data channel among N_REQ internal loaders (IFM, filter, bias, scale). Each granted request is issued as one INCR burst, and the returned beats are routed back to the owning loader. Exactly one burst is outstanding at a time, and a grant is held until RLAST.

## Interface
- N_REQ, 4, number of requesters; client index = bit position
- A, 32, AXI address width
- D, 32, AXI data width
- I, 4, AXI ID width; requires N_REQ <= 2**I
- L, 8, AXI burst-length width
- clk  in  1  clock
- rstn  in  1  reset, asynchronous, active-low
- req_valid  in  N_REQ  per-client request pending
- req_ready  out  N_REQ  one-hot; pulses for one cycle when that client's request is latched
- req_addr  in  N_REQ*A  client k uses slice [k*A +: A]; byte address
- req_len  in  N_REQ*L  client k uses slice [k*L +: L]; AXI ARLEN, beats-1
- rd_data  out  D  registered copy of M_RDATA
- rd_valid  out  N_REQ  one-hot beat valid to the owning client
- rd_last  out  1  last beat of the current burst
- rd_ready  in  N_REQ  per-client beat ready
- M_ARVALID/M_ARREADY/M_ARADDR/M_ARID/M_ARLEN/M_ARSIZE/M_ARBURST/M_ARLOCK/M_ARCACHE/M_ARPROT  AXI4 AR channel, widths per A/I/L
- M_RVALID/M_RREADY/M_RDATA/M_RID/M_RRESP/M_RLAST  AXI4 R channel
- busy  out  1  high in any state other than IDLE
- grant_id  out  clog2(N_REQ)  owner of the current burst
- rd_err  out  1  sticky; set on any beat with RRESP != 2'b00

## Operation
- FSM states: IDLE, ADDR, DATA.
- IDLE:
  - If any req_valid is high, pick a winner. Latch its addr, len and index.
  - Pulse req_ready[winner] in that cycle, then go to ADDR.
- ADDR:
  - M_ARVALID=1. ARADDR, ARLEN and ARID=winner stay stable until M_ARREADY.
  - On handshake, go to DATA.
- DATA:
  - M_RREADY = rd_ready[grant_id] when the output skid register is empty or being drained.
  - Each R handshake loads rd_data, rd_valid[grant_id] and rd_last.
  - When the beat with RLAST is accepted by the client (rd_valid & rd_ready), go to IDLE.
- Round-robin selection:
  - Search starts at last_grant+1 and wraps at N_REQ-1 to 0.
  - last_grant resets to N_REQ-1, so client 0 wins first.
  - last_grant updates only on a grant.
- Constant AR fields: ARSIZE = clog2(D/8), ARBURST = 2'b01, ARLOCK = 0, ARCACHE = 4'b0011, ARPROT = 0.
- req_valid changes while busy are ignored. A client must hold req_valid until its req_ready pulse.
- If M_RID differs from the latched ARID, the beat is still delivered and rd_err is set.
- rd_err clears only on reset.

## Timing
- Reset values:
  - All outputs 0, except grant_id = N_REQ-1 (the last_grant value).
  - State = IDLE. Reset asserted mid-burst abandons the transfer immediately, with no drain.
- Request latency: req_ready in cycle T, M_ARVALID first high in T+1.
- Beat latency: M_RVALID handshake at T, rd_valid at T+1, through a 1-entry registered output stage.
  - Sustained throughput is 1 beat/cycle while rd_ready stays high.
  - rd_ready low deasserts M_RREADY in the same cycle. No beat is dropped.
- Turnaround: the RLAST consume cycle leaves DATA → IDLE in the next cycle, where the next grant may occur. This gives a minimum 2-cycle gap between the last beat and the next ARVALID.
- ARLEN=0 (single beat): DATA handles the first beat as last.
- All N_REQ requests simultaneous: served in round-robin order, one burst each, before any client is served twice.

## Configuration
- YOLO_RD_ARB_FIXED_PRIO_EN
  - Defined: fixed priority; the lowest index among req_valid always wins, and last_grant is unused.
  - Undefined (default): round-robin as above.

## Structure
- Package yolo_axi_pkg holds:
  - AXI_BURST_INCR = 2'b01, AXI_RESP_OKAY = 2'b00, AXI_CACHE_DEFAULT = 4'b0011
  - FSM state typedef {IDLE, ADDR, DATA}
- Sub-module yolo_rr_pick: combinational one-hot/index pick from (req vector, last_grant). The fixed-priority variant is selected inside it by the macro.

## Test plan
- Single request, client 2, addr=0x1000, len=3 → req_ready[2] pulse; ARADDR=0x1000, ARID=2, ARLEN=3; four beats on rd_valid[2]; rd_last on beat 4; busy falls the cycle after.
- Clients 0..3 all valid at once, len=0 each → grants in order 0,1,2,3, then client 0 again if still valid. With YOLO_RD_ARB_FIXED_PRIO_EN and all held valid, client 0 is granted repeatedly.
- M_ARREADY held low 5 cycles → ARVALID stays high, with ARADDR/ARLEN/ARID stable every cycle.
- rd_ready[owner] toggled 1,0,0,1 during an 8-beat burst → M_RREADY follows; all 8 data words delivered in order, none duplicated.
- Beat 2 of 4 returns RRESP=2'b10 → rd_err rises and stays 1 after the burst and through later bursts until rstn.
- rstn pulled low mid-burst (beat 3 of 8) → all outputs 0 asynchronously. After release, a new request from client 1 is granted first, since last_grant resets to N_REQ-1 and client 0 is idle.
